// File: rtl/cmd_bus_pkg.sv
// Shared types and constants for the host-command Wishbone bus master.
package cmd_bus_pkg;

  localparam int CMD_W  = 34;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_SETADDR = 2'b10,
    OP_ILLEGAL = 2'b11
  } opcode_e;

  localparam logic [1:0] RSP_READ    = 2'b00;
  localparam logic [1:0] RSP_WRITE   = 2'b01;
  localparam logic [1:0] RSP_SETADDR = 2'b10;
  localparam logic [1:0] RSP_ERROR   = 2'b11;

  localparam logic [DATA_W-1:0] ERR_BUS     = 32'h0000_0001;
  localparam logic [DATA_W-1:0] ERR_TIMEOUT = 32'h0000_0002;
  localparam logic [DATA_W-1:0] ERR_ILLEGAL = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_BUS    = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  function automatic logic [CMD_W-1:0] mk_rsp(input logic [1:0] code,
                                               input logic [DATA_W-1:0] payload);
    return {code, payload};
  endfunction

endpackage

// File: rtl/cmd_bus_timeout.sv
// Loadable down-counter that flags when a bus cycle has used up its wait budget.
module cmd_bus_timeout #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with budget-1, so zero is reached in the last permitted stb cycle.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_bus_master.sv
// Turns 34-bit host command words into single Wishbone-classic transactions
// and returns exactly one response word per accepted command.
module cmd_bus_master
  import cmd_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_stb,
  input  logic [CMD_W-1:0]  cmd_word,
  output logic              cmd_busy,
  output logic              rsp_stb,
  output logic [CMD_W-1:0]  rsp_word,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data_w,
  output logic [3:0]        wb_sel,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic [DATA_W-1:0] wb_data_r
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                inc_q;
  logic                busy_q;
  logic                rsp_stb_q;
  logic [CMD_W-1:0]    rsp_word_q;
  logic                wb_cyc_q;
  logic                wb_stb_q;
  logic                wb_we_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wb_data_w_q;
  logic [3:0]          wb_sel_q;

  opcode_e             cmd_op;
  logic [ADDR_W-1:0]   set_addr_val;
  logic                tmo_expired;

  assign cmd_op = opcode_e'(cmd_q[33:32]);

  // Relative SET_ADDR wraps naturally in the 30-bit adder.
  assign set_addr_val = cmd_q[31] ? (addr_q + cmd_q[ADDR_W-1:0]) : cmd_q[ADDR_W-1:0];

  cmd_bus_timeout #(
    .CNT_W (TMO_W)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == ST_DECODE),
    .load_val_i (TMO_LOAD),
    .en_i       (state_q == ST_BUS),
    .expired_o  (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      inc_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_stb_q   <= 1'b0;
      rsp_word_q  <= '0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_w_q <= '0;
      wb_sel_q    <= 4'h0;
    end else begin
      rsp_stb_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_stb) begin
            cmd_q   <= cmd_word;
            busy_q  <= 1'b1;
            state_q <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (cmd_op)
            OP_SETADDR: begin
              addr_q     <= set_addr_val;
              inc_q      <= cmd_q[30];
              rsp_word_q <= mk_rsp(RSP_SETADDR, {2'b00, set_addr_val});
              rsp_stb_q  <= 1'b1;
              state_q    <= ST_RESP;
            end
            OP_WRITE, OP_READ: begin
              wb_cyc_q    <= 1'b1;
              wb_stb_q    <= 1'b1;
              wb_we_q     <= (cmd_op == OP_WRITE);
              wb_addr_q   <= addr_q;
              wb_data_w_q <= cmd_q[DATA_W-1:0];
              wb_sel_q    <= 4'hF;
              state_q     <= ST_BUS;
            end
            default: begin
              rsp_word_q <= mk_rsp(RSP_ERROR, ERR_ILLEGAL);
              rsp_stb_q  <= 1'b1;
              state_q    <= ST_RESP;
            end
          endcase
        end

        ST_BUS: begin
          // Error outranks a simultaneous ack; ack outranks an expiring budget.
          if (wb_err || wb_ack || tmo_expired) begin
            wb_cyc_q  <= 1'b0;
            wb_stb_q  <= 1'b0;
            wb_sel_q  <= 4'h0;
            rsp_stb_q <= 1'b1;
            state_q   <= ST_RESP;
            if (wb_err) begin
              rsp_word_q <= mk_rsp(RSP_ERROR, ERR_BUS);
            end else if (wb_ack) begin
              rsp_word_q <= wb_we_q ? mk_rsp(RSP_WRITE, {2'b00, wb_addr_q})
                                    : mk_rsp(RSP_READ, wb_data_r);
              if (inc_q) begin
                addr_q <= addr_q + 30'd1;
              end
            end else begin
              rsp_word_q <= mk_rsp(RSP_ERROR, ERR_TIMEOUT);
            end
          end
        end

        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_busy  = busy_q;
  assign rsp_stb   = rsp_stb_q;
  assign rsp_word  = rsp_word_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data_w = wb_data_w_q;
  assign wb_sel    = wb_sel_q;

endmodule

// File: tb/tb_cmd_bus_master.sv
// Directed bench for cmd_bus_master: vector table plus reset/busy/stray-ack sequences.
module tb_cmd_bus_master;

  localparam int M_ACK = 0, M_ERR = 1, M_ERRACK = 2, M_SILENT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_stb = 1'b0;
  logic [33:0] cmd_word = '0;
  logic        cmd_busy, rsp_stb;
  logic [33:0] rsp_word;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [29:0] wb_addr;
  logic [31:0] wb_data_w, wb_data_r;
  logic [3:0]  wb_sel;

  int checks = 0;
  int failures = 0;

  int slave_mode = M_ACK;
  int slave_wait = 0;
  int wait_cnt = 0;
  logic stray_ack = 1'b0;
  logic [31:0] mem [16];

  int stb_cycles = 0;
  int rsp_count = 0;
  int sel_bad = 0;
  logic stb_prev = 1'b0;
  logic [29:0] start_addr = '0;
  logic start_we = 1'b0;

  always #5 clk = ~clk;

  cmd_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_stb   (cmd_stb),
    .cmd_word  (cmd_word),
    .cmd_busy  (cmd_busy),
    .rsp_stb   (rsp_stb),
    .rsp_word  (rsp_word),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data_w (wb_data_w),
    .wb_sel    (wb_sel),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_data_r (wb_data_r)
  );

  // Slave model: terminates after slave_wait stb cycles in the selected mode.
  always_comb begin
    wb_ack = stray_ack;
    wb_err = 1'b0;
    if (wb_cyc && wb_stb && (wait_cnt == slave_wait)) begin
      if (slave_mode == M_ACK || slave_mode == M_ERRACK) wb_ack = 1'b1;
      if (slave_mode == M_ERR || slave_mode == M_ERRACK) wb_err = 1'b1;
    end
  end
  assign wb_data_r = mem[wb_addr[3:0]];

  always @(posedge clk) begin
    wait_cnt <= wb_stb ? wait_cnt + 1 : 0;
    if (wb_cyc && wb_stb && wb_ack && !wb_err && wb_we) mem[wb_addr[3:0]] <= wb_data_w;
  end

  always @(negedge clk) begin
    if (wb_stb) begin
      stb_cycles <= stb_cycles + 1;
      if (!stb_prev) begin
        start_addr <= wb_addr;
        start_we   <= wb_we;
      end
      if (wb_sel != 4'hF) sel_bad <= sel_bad + 1;
    end
    stb_prev <= wb_stb;
    if (rsp_stb) rsp_count <= rsp_count + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one command when idle; report response, latency in cycles and busy at N+1.
  task automatic run_cmd(input logic [33:0] w, output logic [33:0] rsp,
                         output int lat, output logic busy1);
    int k;
    k = 0;
    lat = -1;
    rsp = '0;
    busy1 = 1'b0;
    while (cmd_busy && k < 50) begin
      step();
      k++;
    end
    cmd_word = w;
    cmd_stb  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) begin
        cmd_stb = 1'b0;
        busy1 = cmd_busy;
      end
      if (rsp_stb) begin
        lat = i;
        rsp = rsp_word;
        break;
      end
    end
  endtask

  function automatic logic [33:0] sa(input logic rel, input logic inc, input logic [29:0] a);
    return {2'b10, rel, inc, a};
  endfunction

  typedef struct {
    logic [33:0] cmd;
    int          mode;
    int          wait_st;
    logic [33:0] exp_rsp;
    int          exp_lat;
    int          exp_stb;
    logic [29:0] exp_addr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    logic [33:0] rsp;
    int lat, stb_base, rsp_base, k;
    logic busy1;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[12] = 32'h1234_5678;
    mem[2]  = 32'hCAFE_0002;
    mem[15] = 32'h0F0F_0F0F;
    mem[3]  = 32'h3333_3333;

    vecs[0]  = '{sa(0, 1, 30'hC),          M_ACK,    0, {2'b10, 32'h0000_000C}, 2, 0, 30'h0};
    vecs[1]  = '{{2'b00, 32'h0},           M_ACK,    0, {2'b00, 32'h1234_5678}, 3, 1, 30'hC};
    vecs[2]  = '{sa(1, 1, 30'h0),          M_ACK,    0, {2'b10, 32'h0000_000D}, 2, 0, 30'h0};
    vecs[3]  = '{sa(0, 1, 30'h0),          M_ACK,    0, {2'b10, 32'h0000_0000}, 2, 0, 30'h0};
    vecs[4]  = '{{2'b01, 32'hAABB_CCDD},   M_ACK,    0, {2'b01, 32'h0000_0000}, 3, 1, 30'h0};
    vecs[5]  = '{{2'b01, 32'hAABB_CCDD},   M_ACK,    0, {2'b01, 32'h0000_0001}, 3, 1, 30'h1};
    vecs[6]  = '{{2'b00, 32'h0},           M_ACK,    2, {2'b00, 32'hCAFE_0002}, 5, 3, 30'h2};
    vecs[7]  = '{sa(0, 1, 30'h3FFF_FFFF),  M_ACK,    0, {2'b10, 32'h3FFF_FFFF}, 2, 0, 30'h0};
    vecs[8]  = '{{2'b00, 32'h0},           M_ACK,    0, {2'b00, 32'h0F0F_0F0F}, 3, 1, 30'h3FFF_FFFF};
    vecs[9]  = '{{2'b00, 32'h0},           M_ACK,    0, {2'b00, 32'hAABB_CCDD}, 3, 1, 30'h0};
    vecs[10] = '{sa(0, 1, 30'h5),          M_ACK,    0, {2'b10, 32'h0000_0005}, 2, 0, 30'h0};
    vecs[11] = '{{2'b01, 32'h5555_5555},   M_ERR,    1, {2'b11, 32'h0000_0001}, 4, 2, 30'h5};
    vecs[12] = '{{2'b00, 32'h0},           M_ERRACK, 0, {2'b11, 32'h0000_0001}, 3, 1, 30'h5};
    vecs[13] = '{{2'b00, 32'h0},           M_SILENT, 0, {2'b11, 32'h0000_0002}, 6, 4, 30'h5};
    vecs[14] = '{sa(1, 1, 30'h0),          M_ACK,    0, {2'b10, 32'h0000_0005}, 2, 0, 30'h0};
    vecs[15] = '{{2'b11, 32'h0000_1234},   M_ACK,    0, {2'b11, 32'h0000_0003}, 2, 0, 30'h0};
    vecs[16] = '{sa(1, 0, 30'h3FFF_FFFE),  M_ACK,    0, {2'b10, 32'h0000_0003}, 2, 0, 30'h0};
    vecs[17] = '{{2'b00, 32'h0},           M_ACK,    0, {2'b00, 32'h3333_3333}, 3, 1, 30'h3};
    vecs[18] = '{sa(1, 0, 30'h0),          M_ACK,    0, {2'b10, 32'h0000_0003}, 2, 0, 30'h0};

    repeat (3) step();
    check("reset_busy",  64'(cmd_busy), 64'd0);
    check("reset_rsp",   64'({rsp_stb, rsp_word}), 64'd0);
    check("reset_wb",    64'({wb_cyc, wb_stb, wb_we, wb_sel}), 64'd0);
    check("reset_addr",  64'({wb_addr, wb_data_w}), 64'd0);
    reset = 1'b0;
    step();

    for (int v = 0; v < NV; v++) begin
      slave_mode = vecs[v].mode;
      slave_wait = vecs[v].wait_st;
      stb_base = stb_cycles;
      run_cmd(vecs[v].cmd, rsp, lat, busy1);
      check($sformatf("v%0d_rsp", v), 64'(rsp), 64'(vecs[v].exp_rsp));
      check($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_busy", v), 64'(busy1), 64'd1);
      check($sformatf("v%0d_stb_cycles", v), 64'(stb_cycles - stb_base), 64'(vecs[v].exp_stb));
      if (vecs[v].exp_stb > 0) begin
        check($sformatf("v%0d_bus_addr", v), 64'(start_addr), 64'(vecs[v].exp_addr));
        check($sformatf("v%0d_bus_we", v), 64'(start_we), 64'(vecs[v].cmd[33:32] == 2'b01));
      end
    end
    check("mem1_written", 64'(mem[1]), 64'hAABB_CCDD);
    check("mem5_not_written", 64'(mem[5]), 64'h0);
    check("sel_during_stb", 64'(sel_bad), 64'd0);

    // Stray ack while idle must produce nothing.
    rsp_base = rsp_count;
    stray_ack = 1'b1;
    repeat (3) step();
    stray_ack = 1'b0;
    check("stray_ack_no_rsp", 64'(rsp_count - rsp_base), 64'd0);
    check("stray_ack_no_cyc", 64'(wb_cyc), 64'd0);

    // cmd_stb held through busy is accepted only once.
    slave_mode = M_ACK;
    run_cmd(sa(0, 0, 30'h10), rsp, lat, busy1);
    step();
    rsp_base = rsp_count;
    cmd_word = sa(1, 0, 30'h1);
    cmd_stb = 1'b1;
    repeat (3) step();
    cmd_stb = 1'b0;
    repeat (4) step();
    check("held_stb_one_rsp", 64'(rsp_count - rsp_base), 64'd1);
    run_cmd(sa(1, 0, 30'h0), rsp, lat, busy1);
    check("held_stb_addr", 64'(rsp), 64'({2'b10, 32'h0000_0011}));

    // Reset in the middle of a bus cycle.
    run_cmd(sa(0, 1, 30'h7), rsp, lat, busy1);
    slave_mode = M_SILENT;
    step();
    cmd_word = {2'b00, 32'h0};
    cmd_stb = 1'b1;
    step();
    cmd_stb = 1'b0;
    k = 0;
    while (!wb_cyc && k < 10) begin
      step();
      k++;
    end
    check("rst_bus_started", 64'(wb_cyc), 64'd1);
    rsp_base = rsp_count;
    reset = 1'b1;
    step();
    check("rst_cyc_dropped", 64'({wb_cyc, wb_stb, wb_sel}), 64'd0);
    check("rst_busy_clear", 64'(cmd_busy), 64'd0);
    reset = 1'b0;
    repeat (8) step();
    check("rst_no_rsp", 64'(rsp_count - rsp_base), 64'd0);
    slave_mode = M_ACK;
    run_cmd(sa(1, 0, 30'h0), rsp, lat, busy1);
    check("rst_addr_zero", 64'(rsp), 64'({2'b10, 32'h0000_0000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
